// File: rtl/setcc_seq_pkg.sv
// Shared opcode, state and sizing definitions for the iterative
// set-condition coprocessor.
package setcc_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    localparam logic [1:0] SETCC_SEQ = 2'b00;
    localparam logic [1:0] SETCC_SLT = 2'b01;
    localparam logic [1:0] SETCC_SLE = 2'b10;
    localparam logic [1:0] SETCC_SCO = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/setcc_seq_slice_adder.sv
// Narrow ripple slice shared by every CALC cycle of setcc_seq.
// Purely combinational: sum and carry-out of a + b + cin.
module slice_adder #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    assign sum  = full[SLICE-1:0];
    assign cout = full[SLICE];

endmodule

// File: rtl/setcc_seq.sv
// Iterative SEQ/SLT/SLE/SCO unit: one SLICE-bit adder stepped LSB-first,
// valid/ready on both sides so the execute stage can stall on it.
module setcc_seq
    import setcc_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_set,
    output logic             busy
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] opx, opy;
    logic             carry, nz, msb;
    logic [1:0]       op;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] sum;
    logic             cout;
    logic             last;
    logic             accept;
    logic             cond;

    slice_adder #(.SLICE(SLICE)) u_add (
        .a    (opx[SLICE-1:0]),
        .b    (opy[SLICE-1:0]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = IDLE;
        unique case (1'b1)
            state == IDLE: state_n = accept ? CALC : IDLE;
            state == CALC: state_n = last ? DONE : CALC;
            state == DONE: state_n = out_ready ? IDLE : DONE;
            default:       state_n = IDLE;
        endcase
    end

    // Operands are pre-arranged so every op is a plain add: A-B, B-A or A+B.
    always_ff @(posedge clk) begin
        if (rst) begin
            opx   <= '0;
            opy   <= '0;
            carry <= 1'b0;
            nz    <= 1'b0;
            msb   <= 1'b0;
            op    <= SETCC_SEQ;
            cnt   <= '0;
        end else if (accept) begin
            op  <= in_op;
            cnt <= '0;
            nz  <= 1'b0;
            msb <= 1'b0;
            case (in_op)
                SETCC_SLE: begin
                    opx   <= in_b;
                    opy   <= ~in_a;
                    carry <= 1'b1;
                end
                SETCC_SCO: begin
                    opx   <= in_a;
                    opy   <= in_b;
                    carry <= 1'b0;
                end
                default: begin
                    opx   <= in_a;
                    opy   <= ~in_b;
                    carry <= 1'b1;
                end
            endcase
        end else if (state == CALC) begin
            opx   <= opx >> SLICE;
            opy   <= opy >> SLICE;
            carry <= cout;
            nz    <= nz | (|sum);
            msb   <= sum[SLICE-1];
            cnt   <= cnt + 1'b1;
        end
    end

    // Flags freeze in DONE, so the result stays stable until handshake.
    always_comb begin
        cond = 1'b0;
        case (op)
            SETCC_SEQ: cond = !nz;
            SETCC_SLT: cond = msb;
            SETCC_SLE: cond = !msb;
            SETCC_SCO: cond = carry;
            default:   cond = 1'b0;
        endcase
    end

    assign out_set = {{(WIDTH-1){1'b0}}, out_valid & cond};

endmodule

// File: tb/tb_setcc_seq.sv
// Directed self-checking bench for setcc_seq at WIDTH=16, SLICE=4.
module tb_setcc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_set;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    setcc_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_set   (out_set),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept at edge E0, expect out_valid exactly after E4.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp,
                          input string tag);
        logic early;
        early = 1'b0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_op = op;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op = ~op;
        in_a = ~a;
        in_b = ~b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            early = early | out_valid;
            @(posedge clk);
        end
        chk({tag, "_early"}, {31'd0, early}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_set"}, {16'd0, out_set}, {16'd0, exp});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {29'd0, in_ready, out_valid, busy}, 32'd4);
    endtask

    initial begin
        logic any_v;
        rst = 1'b1;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {13'd0, in_ready, out_valid, busy, out_set},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});

        run_op(2'b00, 16'h1234, 16'h1234, 16'h0001, "seq_eq");
        run_op(2'b00, 16'h1234, 16'h1235, 16'h0000, "seq_ne");
        run_op(2'b01, 16'h0003, 16'h0005, 16'h0001, "slt_lt");
        run_op(2'b01, 16'h8000, 16'h0001, 16'h0000, "slt_noovf");
        run_op(2'b10, 16'h0005, 16'h0005, 16'h0001, "sle_eq");
        run_op(2'b10, 16'h0006, 16'h0005, 16'h0000, "sle_gt");
        run_op(2'b11, 16'hFFFF, 16'h0001, 16'h0001, "sco_c");
        run_op(2'b11, 16'h7FFF, 16'h0001, 16'h0000, "sco_nc");

        // Backpressure: SEQ equal, hold out_ready low with new requests.
        @(negedge clk);
        in_op = 2'b00;
        in_a = 16'hABCD;
        in_b = 16'hABCD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op = 2'b11;
        in_a = 16'h0001;
        in_b = 16'h0002;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold", {12'd0, out_valid, in_ready, busy, 1'b0, out_set},
                {12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001});
            @(posedge clk);
            #1;
            in_a = in_a + 16'h0011;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {13'd0, in_ready, out_valid, busy, out_set},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});

        // Reset on the second CALC cycle aborts the SCO.
        in_op = 2'b11;
        in_a = 16'hFFFF;
        in_b = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort", {13'd0, in_ready, out_valid, busy, out_set},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        any_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            any_v = any_v | out_valid | busy;
        end
        chk("rst_no_result", {31'd0, any_v}, 32'd0);

        run_op(2'b01, 16'h0005, 16'h0003, 16'h0000, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        failed++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/setcc_seq.md
Name: setcc_seq

Overview:
- Iterative set-condition unit that executes SEQ, SLT, SLE and SCO on two WIDTH-bit operands.
- Holds one SLICE-bit adder and steps it LSB-first over WIDTH/SLICE cycles, accumulating carry, zero and MSB flags.
- Evaluates the condition once the final slice completes.
- Sits beside the execute stage as a valid/ready coprocessor, so the stage stalls on set instructions instead of instancing a full-width subtractor.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per CALC cycle; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- in_op  input  2  condition: 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_set  output  WIDTH  result; bit 0 = condition, all upper bits 0.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk. It has priority over all other inputs and is honoured mid-operation.
- Reset state: state=IDLE, in_ready=1, out_valid=0, busy=0, out_set=0. Operand, carry, flag and slice counter registers are cleared.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, busy=1.
  - DONE: out_valid=1, busy=1.
- IDLE→CALC on in_valid&&in_ready.
- Registration at accept, by op:
  - SEQ/SLT: opx=A, opy=~B, carry=1 (computes A−B).
  - SLE: opx=B, opy=~A, carry=1 (computes B−A).
  - SCO: opx=A, opy=B, carry=0 (computes A+B).
  - Also at accept: slice counter=0, nz (sticky nonzero)=0, op stored.
- Each CALC cycle:
  - sum = opx[SLICE-1:0] + opy[SLICE-1:0] + carry.
  - carry ← carry-out of that sum.
  - nz ← nz | (sum≠0).
  - msb ← sum[SLICE-1].
  - opx and opy shift right by SLICE.
  - Counter increments.
- CALC→DONE on the edge that processes slice WIDTH/SLICE−1. out_set is registered on that same edge.
  - SEQ: !nz.
  - SLT: msb.
  - SLE: !msb.
  - SCO: carry.
- SLT and SLE use raw result MSB with no overflow correction. This is the defined ISA semantics.
- Latency: accept at edge 0, out_valid high after edge WIDTH/SLICE (4 cycles at defaults).
- DONE: out_set and out_valid are held stable until out_ready.
  - On the edge where out_valid&&out_ready: go to IDLE, out_valid←0, out_set←0.
- No back-to-back accept in the same cycle as output handshake. in_ready asserts the cycle after return to IDLE. Maximum throughput is one op per WIDTH/SLICE+2 cycles.
- in_op, in_a and in_b are ignored outside the accept cycle, so changes during CALC or DONE have no effect.
- in_valid while not in_ready is not accepted. The requester must hold the request.
- out_ready while not out_valid has no effect.
- rst during CALC or DONE aborts. The next cycle shows the reset state and the pending result is discarded.
- Unreachable state encodings return to IDLE.

Decomposition:
- Shared package:
  - Opcode constants SETCC_SEQ/SLT/SLE/SCO (2-bit).
  - State encoding IDLE/CALC/DONE.
  - Default WIDTH/SLICE.
- Sub-module slice_adder: SLICE-bit a, b, cin in; sum and cout out. It is purely combinational and instanced once.
- Counter, flag registers and FSM stay in setcc_seq.

Test Plan:
- SEQ A=0x1234 B=0x1234 -> out_valid exactly 4 cycles after accept, out_set=0x0001. Repeat with B=0x1235 -> 0x0000.
- SLT A=0x0003 B=0x0005 -> 0x0001. A=0x8000 B=0x0001 (diff 0x7FFF) -> 0x0000, confirming no overflow correction.
- SLE A=0x0005 B=0x0005 -> 0x0001. A=0x0006 B=0x0005 -> 0x0000.
- SCO A=0xFFFF B=0x0001 -> 0x0001. A=0x7FFF B=0x0001 -> 0x0000.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid. Required: out_set stable, in_ready=0, busy=1, and in_valid with new operands ignored. Raise out_ready -> IDLE next cycle and in_ready=1.
- Reset mid-op: accept SCO, assert rst on the second CALC cycle -> next cycle in_ready=1, out_valid=0, busy=0, out_set=0. No result ever appears for the aborted op.
